// File: rtl/gameover_overlay_ctrl.sv
// gameover_overlay_ctrl
// Places the game-over banner sprite over the background pixel stream and
// runs the game-over sequence: PLAY -> BLINK -> SHOW -> RESTART -> PLAY.
// Beam coordinates are turned into banner-local ROM coordinates in stage 1.
// The ROM returns its colour combinationally, and stage 2 composites it.
// The input-to-output latency is 2 cycles.
// Optional macro DIM_BG_EN halves the background outside PLAY.
//
// state   | meaning
// --------+-----------------------------------------------------------
// PLAY    | normal play, banner hidden, waiting for game_over rising edge
// BLINK   | banner blinks once per BLINK_FRAMES frames, BLINK_TOGGLES times
// SHOW    | banner steady, start_btn accepted after LOCK_FRAMES frames
// RESTART | single-cycle restart pulse, banner cleared
module gameover_overlay_ctrl #(
    parameter int BANNER_X0     = 192,
    parameter int BANNER_Y0     = 224,
    parameter int BANNER_W      = 256,
    parameter int BANNER_H      = 32,
    parameter int BLINK_FRAMES  = 30,
    parameter int BLINK_TOGGLES = 6,
    parameter int LOCK_FRAMES   = 120
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] hcount_i,
    input  logic [9:0] vcount_i,
    input  logic       video_on_i,
    input  logic       frame_tick_i,
    input  logic       game_over_i,
    input  logic       start_btn_i,
    input  logic [7:0] bg_r_i,
    input  logic [7:0] bg_g_i,
    input  logic [7:0] bg_b_i,
    output logic [9:0] spr_x_o,
    output logic [9:0] spr_y_o,
    input  logic [7:0] spr_r_i,
    input  logic [7:0] spr_g_i,
    input  logic [7:0] spr_b_i,
    input  logic       spr_a_i,
    output logic [7:0] out_r_o,
    output logic [7:0] out_g_o,
    output logic [7:0] out_b_o,
    output logic       out_de_o,
    output logic       restart_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_BLINK   = 2'd1,
        ST_SHOW    = 2'd2,
        ST_RESTART = 2'd3
    } state_t;

    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    localparam int LW = $clog2(LOCK_FRAMES + 1);

    localparam logic [9:0]    X_LO        = 10'(BANNER_X0);
    localparam logic [9:0]    X_HI        = 10'(BANNER_X0 + BANNER_W - 1);
    localparam logic [9:0]    Y_LO        = 10'(BANNER_Y0);
    localparam logic [9:0]    Y_HI        = 10'(BANNER_Y0 + BANNER_H - 1);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(BLINK_TOGGLES - 1);
    localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_FRAMES);

    state_t        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [TW-1:0] toggle_q, toggle_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          visible_q, visible_d;
    // The first frame_tick in BLINK only turns the banner on; blink timing
    // starts from that tick.
    logic          started_q, started_d;
    logic          go_prev_q, start_prev_q;

    logic          in_win;
    logic          in_win_q, de1_q;
    logic [7:0]    bg1_r_q, bg1_g_q, bg1_b_q;
    logic [9:0]    spr_x_q, spr_y_q;
    logic          dim;
    logic [7:0]    out_r_d, out_g_d, out_b_d;
    logic [7:0]    out_r_q, out_g_q, out_b_q;
    logic          out_de_q;

    wire go_rise    = game_over_i & ~go_prev_q;
    wire start_rise = start_btn_i & ~start_prev_q;

    // FSM and counter registers. Edge detectors reload the current level on
    // reset, so an input held high through reset does not create an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_PLAY;
            frame_q      <= '0;
            toggle_q     <= '0;
            lock_q       <= '0;
            visible_q    <= 1'b0;
            started_q    <= 1'b0;
            go_prev_q    <= game_over_i;
            start_prev_q <= start_btn_i;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            toggle_q     <= toggle_d;
            lock_q       <= lock_d;
            visible_q    <= visible_d;
            started_q    <= started_d;
            go_prev_q    <= game_over_i;
            start_prev_q <= start_btn_i;
        end
    end

    // Next-state logic. Visibility moves only on frame_tick, except for the
    // forced clear when a restart is taken.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        toggle_d  = toggle_q;
        lock_d    = lock_q;
        visible_d = visible_q;
        started_d = started_q;
        case (state_q)
            ST_PLAY: begin
                visible_d = 1'b0;
                if (go_rise) begin
                    state_d   = ST_BLINK;
                    frame_d   = '0;
                    toggle_d  = '0;
                    started_d = 1'b0;
                end
            end
            ST_BLINK: begin
                if (frame_tick_i) begin
                    if (!started_q) begin
                        started_d = 1'b1;
                        visible_d = 1'b1;
                    end else if (frame_q == FRAME_LAST) begin
                        frame_d   = '0;
                        visible_d = ~visible_q;
                        toggle_d  = toggle_q + 1'b1;
                        if (toggle_q == TOGGLE_LAST) begin
                            state_d   = ST_SHOW;
                            visible_d = 1'b1;
                            lock_d    = '0;
                        end
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                visible_d = 1'b1;
                if (frame_tick_i && lock_q != LOCK_MAX) begin
                    lock_d = lock_q + 1'b1;
                end
                if (start_rise && lock_q == LOCK_MAX) begin
                    state_d   = ST_RESTART;
                    visible_d = 1'b0;
                end
            end
            ST_RESTART: begin
                state_d   = ST_PLAY;
                visible_d = 1'b0;
                frame_d   = '0;
                toggle_d  = '0;
                lock_d    = '0;
                started_d = 1'b0;
            end
            default: state_d = ST_PLAY;
        endcase
    end

    assign in_win = (hcount_i >= X_LO) && (hcount_i <= X_HI) &&
                    (vcount_i >= Y_LO) && (vcount_i <= Y_HI);

    // Stage 1: window test and banner-local coordinates for the ROM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_win_q <= 1'b0;
            de1_q    <= 1'b0;
            bg1_r_q  <= '0;
            bg1_g_q  <= '0;
            bg1_b_q  <= '0;
            spr_x_q  <= '0;
            spr_y_q  <= '0;
        end else begin
            in_win_q <= in_win;
            de1_q    <= video_on_i;
            bg1_r_q  <= bg_r_i;
            bg1_g_q  <= bg_g_i;
            bg1_b_q  <= bg_b_i;
            spr_x_q  <= in_win ? (hcount_i - X_LO) : 10'd0;
            spr_y_q  <= in_win ? (vcount_i - Y_LO) : 10'd0;
        end
    end

`ifdef DIM_BG_EN
    assign dim = (state_q != ST_PLAY);
`else
    assign dim = 1'b0;
`endif

    // Stage 2 mux: blanking, opaque banner pixel, or (optionally dimmed) background.
    always_comb begin
        out_r_d = 8'd0;
        out_g_d = 8'd0;
        out_b_d = 8'd0;
        if (de1_q) begin
            if (in_win_q && visible_q && spr_a_i) begin
                out_r_d = spr_r_i;
                out_g_d = spr_g_i;
                out_b_d = spr_b_i;
            end else if (dim) begin
                out_r_d = {1'b0, bg1_r_q[7:1]};
                out_g_d = {1'b0, bg1_g_q[7:1]};
                out_b_d = {1'b0, bg1_b_q[7:1]};
            end else begin
                out_r_d = bg1_r_q;
                out_g_d = bg1_g_q;
                out_b_d = bg1_b_q;
            end
        end
    end

    // Stage 2 register: composited pixel and delayed data enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_r_q  <= '0;
            out_g_q  <= '0;
            out_b_q  <= '0;
            out_de_q <= 1'b0;
        end else begin
            out_r_q  <= out_r_d;
            out_g_q  <= out_g_d;
            out_b_q  <= out_b_d;
            out_de_q <= de1_q;
        end
    end

    assign spr_x_o   = spr_x_q;
    assign spr_y_o   = spr_y_q;
    assign out_r_o   = out_r_q;
    assign out_g_o   = out_g_q;
    assign out_b_o   = out_b_q;
    assign out_de_o  = out_de_q;
    assign restart_o = (state_q == ST_RESTART);
    assign state_o   = state_q;

endmodule

// File: tb/tb_gameover_overlay_ctrl.sv
// Testbench for gameover_overlay_ctrl using short blink and lock timings.
// Each stimulus cycle updates a phase-level model of the game-over sequence.
// The expected pixel, coordinate and state values are queued with the cycle
// in which they must appear, and a negedge monitor compares them.
module tb_gameover_overlay_ctrl;

    localparam int X0 = 192, Y0 = 224, W = 256, H = 32;
    localparam int BF = 2, BT = 4, LK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcount = '0, vcount = '0;
    logic       video_on = 1'b0, frame_tick = 1'b0, game_over = 1'b0, start_btn = 1'b0;
    logic [7:0] bg_r = '0, bg_g = '0, bg_b = '0;
    logic [9:0] spr_x, spr_y;
    logic [7:0] spr_r, spr_g, spr_b;
    logic       spr_a;
    logic [7:0] out_r, out_g, out_b;
    logic       out_de, restart;
    logic [1:0] state;

    // Sprite ROM stand-in: a fixed pattern with some transparent pixels.
    function automatic logic [24:0] rom_px(input logic [9:0] x, input logic [9:0] y);
        logic [7:0] xl, yl;
        xl = x[7:0];
        yl = y[7:0];
        return {~(x[2] & y[1]), xl ^ 8'hA5, yl + 8'h3C, xl + yl};
    endfunction

    assign {spr_a, spr_r, spr_g, spr_b} = rom_px(spr_x, spr_y);

    gameover_overlay_ctrl #(
        .BLINK_FRAMES (BF),
        .BLINK_TOGGLES(BT),
        .LOCK_FRAMES  (LK)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .hcount_i    (hcount),
        .vcount_i    (vcount),
        .video_on_i  (video_on),
        .frame_tick_i(frame_tick),
        .game_over_i (game_over),
        .start_btn_i (start_btn),
        .bg_r_i      (bg_r),
        .bg_g_i      (bg_g),
        .bg_b_i      (bg_b),
        .spr_x_o     (spr_x),
        .spr_y_o     (spr_y),
        .spr_r_i     (spr_r),
        .spr_g_i     (spr_g),
        .spr_b_i     (spr_b),
        .spr_a_i     (spr_a),
        .out_r_o     (out_r),
        .out_g_o     (out_g),
        .out_b_o     (out_b),
        .out_de_o    (out_de),
        .restart_o   (restart),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [23:0] rgb;
        logic        de;
    } pix_t;
    typedef struct {
        int unsigned due;
        logic [1:0]  st;
        logic        rs;
        logic [9:0]  sx;
        logic [9:0]  sy;
    } ctl_t;

    pix_t pq[$];
    ctl_t cq[$];
    int   checks = 0;
    int   errors = 0;
    int   restarts_seen = 0;
    int   shows_seen = 0;

    // The model tracks the phase and counts frame ticks since the phase was entered.
    int m_state = 0;
    int m_n = 0;
    int m_m = 0;
    bit m_vis = 0;
    bit m_pg = 0;
    bit m_ps = 0;

    task automatic model_step(input bit r, input bit go, input bit tk, input bit st);
        bit gr, sr;
        int k;
        if (r) begin
            m_state = 0; m_n = 0; m_m = 0; m_vis = 0;
        end else begin
            gr = go && !m_pg;
            sr = st && !m_ps;
            case (m_state)
                0: begin
                    m_vis = 0;
                    if (gr) begin m_state = 1; m_n = 0; end
                end
                1: if (tk) begin
                    m_n++;
                    k = (m_n - 1) / BF;
                    if (k >= BT) begin m_state = 2; m_m = 0; m_vis = 1; end
                    else m_vis = (k % 2 == 0);
                end
                2: begin
                    if (sr && m_m >= LK) begin m_state = 3; m_vis = 0; end
                    else if (tk) m_m++;
                end
                default: begin m_state = 0; m_vis = 0; end
            endcase
        end
        m_pg = go;
        m_ps = st;
    endtask

    task automatic do_cycle(input bit r, input bit go, input bit tk, input bit st,
                            input int hc, input int vc, input bit de, input logic [23:0] bg);
        bit         inwin, dim;
        int         lx, ly;
        logic [24:0] rp;
        logic [23:0] bgx;
        pix_t       p;
        ctl_t       c;
        rst = r; game_over = go; frame_tick = tk; start_btn = st;
        hcount = 10'(hc); vcount = 10'(vc); video_on = de;
        {bg_r, bg_g, bg_b} = bg;
        model_step(r, go, tk, st);
        inwin = hc >= X0 && hc < X0 + W && vc >= Y0 && vc < Y0 + H;
        lx = inwin ? hc - X0 : 0;
        ly = inwin ? vc - Y0 : 0;
        rp = rom_px(10'(lx), 10'(ly));
        dim = 0;
`ifdef DIM_BG_EN
        dim = (m_state != 0);
`endif
        bgx = dim ? {1'b0, bg[23:17], 1'b0, bg[15:9], 1'b0, bg[7:1]} : bg;
        p.due = cyc + 2;
        p.de  = r ? 1'b0 : de;
        if (r || !de) p.rgb = 24'h0;
        else if (inwin && m_vis && rp[24]) p.rgb = rp[23:0];
        else p.rgb = bgx;
        if (r && pq.size() > 0 && pq[$].due == cyc + 1) begin
            pq[$].rgb = 24'h0;
            pq[$].de  = 1'b0;
        end
        pq.push_back(p);
        c.due = cyc + 1;
        c.st  = 2'(m_state);
        c.rs  = (m_state == 3);
        c.sx  = r ? 10'd0 : 10'(lx);
        c.sy  = r ? 10'd0 : 10'(ly);
        cq.push_back(c);
    endtask

    // Monitor: compares each queued expectation in the cycle it falls due.
    always @(negedge clk) begin
        if (restart) restarts_seen++;
        if (state == 2'd2) shows_seen++;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            pix_t p;
            p = pq.pop_front();
            checks++;
            if (p.due != cyc || out_de !== p.de || {out_r, out_g, out_b} !== p.rgb) begin
                errors++;
                $display("FAIL pixel cyc=%0d due=%0d got de=%0b rgb=%06h exp de=%0b rgb=%06h",
                         cyc, p.due, out_de, {out_r, out_g, out_b}, p.de, p.rgb);
            end
        end
        while (cq.size() > 0 && cq[0].due <= cyc) begin
            ctl_t c;
            c = cq.pop_front();
            checks++;
            if (c.due != cyc || state !== c.st || restart !== c.rs || spr_x !== c.sx || spr_y !== c.sy) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got st=%0d rs=%0b sx=%0d sy=%0d exp st=%0d rs=%0b sx=%0d sy=%0d",
                         cyc, state, restart, spr_x, spr_y, c.st, c.rs, c.sx, c.sy);
            end
        end
    end

    initial begin
        bit go_l, st_l, r, tk, de;
        int hc, vc;
        // Reset with game_over held high: no BLINK entry afterwards.
        repeat (3) begin @(posedge clk); #1; do_cycle(1, 1, 0, 0, 200, 230, 1, 24'h123456); end
        repeat (6) begin @(posedge clk); #1; do_cycle(0, 1, 1, 0, 200, 230, 1, 24'h123456); end
        repeat (2) begin @(posedge clk); #1; do_cycle(0, 0, 0, 0, 10, 10, 0, 24'h0); end
        // game_over rising edge on the same cycle as a frame tick.
        @(posedge clk); #1; do_cycle(0, 1, 1, 0, 192, 224, 1, 24'h111111);
        repeat (3) begin @(posedge clk); #1; do_cycle(0, 1, 0, 0, 192, 224, 1, 24'h222222); end
        @(posedge clk); #1; do_cycle(0, 1, 1, 0, 192, 224, 1, 24'h333333);
        repeat (3) begin @(posedge clk); #1; do_cycle(0, 1, 0, 0, 192, 224, 1, 24'h444444); end
        @(posedge clk); #1; do_cycle(0, 1, 0, 0, 191, 224, 1, 24'h555555);
        @(posedge clk); #1; do_cycle(0, 1, 0, 0, 447, 255, 1, 24'h666666);
        @(posedge clk); #1; do_cycle(0, 1, 0, 0, 448, 255, 1, 24'h80FF02);
        // Reset in the middle of BLINK.
        @(posedge clk); #1; do_cycle(1, 1, 0, 0, 200, 230, 1, 24'h777777);
        repeat (4) begin @(posedge clk); #1; do_cycle(0, 1, 1, 0, 200, 230, 1, 24'h888888); end

        go_l = 1; st_l = 0;
        for (int i = 0; i < 6000; i++) begin
            r  = ($urandom_range(0, 999) == 0);
            tk = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) go_l = ~go_l;
            if ($urandom_range(0, 5) == 0) st_l = ~st_l;
            de = ($urandom_range(0, 7) != 0);
            hc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(180, 460)) : int'($urandom_range(0, 799));
            vc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(215, 265)) : int'($urandom_range(0, 524));
            @(posedge clk); #1;
            do_cycle(r, go_l, tk, st_l, hc, vc, de, 24'($urandom));
        end
        repeat (4) begin @(posedge clk); #1; do_cycle(0, go_l, 0, st_l, 0, 0, 0, 24'h0); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pq.size() > 1 || cq.size() > 1) begin
            errors++;
            $display("FAIL drain got pix=%0d ctl=%0d pending exp at most 1", pq.size(), cq.size());
        end
        checks++;
        if (restarts_seen == 0 || shows_seen == 0) begin
            errors++;
            $display("FAIL activity got restarts=%0d show_cycles=%0d exp both nonzero",
                     restarts_seen, shows_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gameover_overlay_ctrl.md
Name: gameover_overlay_ctrl

Overview:
Sequences the game-over banner sprite ROM and composites its 1-bit-alpha RGBA output over the game background pixel stream. It converts VGA beam coordinates into banner-local x/y for the ROM and runs the game-over state machine (blink, hold/lockout, wait for restart). It sits between the VGA timing/background renderer and the final RGB output, and issues a restart pulse to game logic.

Parameters:
BANNER_X0, 192, screen x of banner left edge
BANNER_Y0, 224, screen y of banner top edge
BANNER_W, 256, banner width in pixels (matches ROM X)
BANNER_H, 32, banner height in pixels (matches ROM Y)
BLINK_FRAMES, 30, frames per blink half-period
BLINK_TOGGLES, 6, visibility toggles before steady display
LOCK_FRAMES, 120, frames after entering SHOW during which start_btn is ignored

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
hcount  in  10  beam x
vcount  in  10  beam y
video_on  in  1  beam in active area
frame_tick  in  1  one-cycle pulse at start of vblank
game_over  in  1  level from game logic; rising edge starts sequence
start_btn  in  1  debounced start button level
bg_r, bg_g, bg_b  in  8 each  background pixel, aligned with hcount/vcount
spr_x  out  10  banner-local x to sprite ROM
spr_y  out  10  banner-local y to sprite ROM
spr_r, spr_g, spr_b  in  8 each  ROM colour (combinational return of spr_x/spr_y)
spr_a  in  1  ROM alpha
out_r, out_g, out_b  out  8 each  composited pixel
out_de  out  1  delayed video_on
restart  out  1  one-cycle pulse to game logic
state  out  2  current FSM state (debug)

Behaviour:
- Reset (rst=1 at clk edge): state=PLAY, all counters 0, spr_x=spr_y=0, out_*=0, out_de=0, restart=0, banner visible flag=0, edge registers cleared to current input level (no false edge after reset).
- Pipeline, latency 2 cycles from hcount/vcount/bg/video_on to out_*/out_de:
  - Stage 1 (registered): in_win = hcount in [X0, X0+W-1] and vcount in [Y0, Y0+H-1]; spr_x=hcount-X0, spr_y=vcount-Y0 (10-bit, wrap ignored when !in_win, spr_x/spr_y=0 when !in_win); bg, video_on, in_win delayed 1.
  - Stage 2 (registered): if !de1 -> out=0; else if in_win1 & visible & spr_a -> out=spr_rgb; else out=bg1.
- FSM states (encoding PLAY=0, BLINK=1, SHOW=2, RESTART=3):
  - PLAY: visible=0. game_over rising edge -> BLINK, frame counter=0, toggle counter=0, visible set to 1 at next frame_tick.
  - BLINK: on each frame_tick, frame counter++; at BLINK_FRAMES-1 wraps to 0, visible inverts, toggle counter++. After BLINK_TOGGLES toggles -> SHOW with visible=1, lock counter=0.
  - SHOW: visible=1. lock counter++ per frame_tick, saturates at LOCK_FRAMES. start_btn rising edge with lock counter==LOCK_FRAMES -> RESTART; earlier edges discarded (not queued).
  - RESTART: restart=1 for exactly this one cycle, visible=0 -> PLAY.
- visible changes only on frame_tick (no mid-frame tearing), except the forced clear in RESTART.
- game_over edges outside PLAY ignored; start_btn edges outside SHOW ignored.
- game_over rising and frame_tick same cycle in PLAY: enter BLINK; first visibility change at the following frame_tick.
- Reset mid-sequence returns to PLAY, banner hidden, no restart pulse.

Optional Feature:
DIM_BG_EN: when defined, in any state other than PLAY the background contribution (non-banner pixels in active area) is halved per channel (bg>>1, logical). When undefined, background passes unchanged in all states. Banner pixels are never dimmed.

Test Plan:
- Reset, PLAY, hcount=200,vcount=230, bg=0x123456, spr_a=1 -> out=0x123456 two cycles later (banner hidden), spr_x=8, spr_y=6.
- game_over 0->1, 1 frame_tick, beam at (192,224), ROM=0xFFFFFF a=1 -> out=0xFFFFFF; beam at (191,224) -> out=bg, spr_x=spr_y=0.
- BLINK_FRAMES=2, BLINK_TOGGLES=4 -> visible toggles every 2 frame_ticks, state==2 after 4 toggles, visible=1.
- In SHOW, LOCK_FRAMES=3: start edge after 1 frame -> no restart; edge after 3 frames -> restart high exactly 1 cycle, state returns to 0.
- rst asserted in BLINK -> state=0, out_*=0, out_de=0 next cycle; game_over held high through reset -> no re-entry to BLINK.
- DIM_BG_EN defined, state SHOW, bg=0x80FF02 outside window -> out=0x407F01; same in PLAY -> 0x80FF02.
